// File: rtl/ex_pkg.sv
// Shared constants for the MIPS execute stage: ALU operation codes,
// the opcode/funct values the destination decoder needs, and the pipeline bubble.
package ex_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_BEQ  = 4'b1100;
  localparam logic [3:0] ALU_BNE  = 4'b1101;
  localparam logic [3:0] ALU_BLEZ = 4'b1110;
  localparam logic [3:0] ALU_BGTZ = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [31:0] BUBBLE  = 32'd32;

  localparam logic [4:0] REG_RA   = 5'd31;

  // Logical immediates are zero-extended; every other immediate is sign-extended.
  function automatic logic is_logical_op(input logic [3:0] aluop);
    return (aluop == ALU_AND) || (aluop == ALU_OR) || (aluop == ALU_XOR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational MIPS ALU: operand2 selection, the sixteen operations,
// compare flags and branch condition.
module alu_core
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [15:0]     imm,
  input  logic [4:0]      shamt,
  input  logic [3:0]      aluop,
  input  logic            alu_src,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt,
  output logic            gt,
  output logic            branch_cond
);

  logic [XLEN-1:0] operand2;
  logic            ltu;

  always_comb begin
    if (!alu_src) begin
      operand2 = op_b;
    end else if (is_logical_op(aluop)) begin
      operand2 = {{(XLEN-16){1'b0}}, imm};
    end else begin
      operand2 = {{(XLEN-16){imm[15]}}, imm};
    end
  end

  assign lt  = $signed(op_a) < $signed(operand2);
  assign gt  = $signed(op_a) > $signed(operand2);
  assign ltu = op_a < operand2;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    result = op_a - operand2;
    unique case (aluop)
      ALU_AND:  result = op_a & operand2;
      ALU_OR:   result = op_a | operand2;
      ALU_ADD:  result = op_a + operand2;
      ALU_XOR:  result = op_a ^ operand2;
      ALU_NOR:  result = ~(op_a | operand2);
      ALU_SLL:  result = operand2 << shamt;
      ALU_SUB:  result = op_a - operand2;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt};
      ALU_SRL:  result = operand2 >> shamt;
      ALU_SRA:  result = $signed(operand2) >>> shamt;
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, ltu};
      ALU_LUI:  result = operand2 << 16;
      default:  result = op_a - operand2;
    endcase
  end

  assign zero = (result == '0);

  always_comb begin
    branch_cond = 1'b0;
    case (aluop)
      ALU_BEQ:  branch_cond = zero;
      ALU_BNE:  branch_cond = !zero;
      ALU_BLEZ: branch_cond = lt | zero;
      ALU_BGTZ: branch_cond = gt;
      default:  branch_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_stage_unit.sv
// Execute stage: ALU, branch-target adder, destination-register decoder and
// the EX/MEM pipeline register bank.
module ex_stage_unit
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic [31:0]     next_pc,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [3:0]      aluop,
  input  logic            alu_src,
  input  logic            flush,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            lt,
  output logic            gt,
  output logic            branch_cond,
  output logic [31:0]     branch_target,
  output logic [4:0]      ws,
  output logic            we,
  output logic [XLEN-1:0] exmem_alu_result,
  output logic [XLEN-1:0] exmem_b,
  output logic [4:0]      exmem_ws,
  output logic            exmem_we,
  output logic [31:0]     exmem_next_pc
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] dec_ws;
  logic       dec_we;
  logic       unused_rs;

  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign unused_rs = ^instr[25:21];

  alu_core #(.XLEN(XLEN)) u_alu (
    .op_a        (op_a),
    .op_b        (op_b),
    .imm         (instr[15:0]),
    .shamt       (instr[10:6]),
    .aluop       (aluop),
    .alu_src     (alu_src),
    .result      (alu_result),
    .zero        (zero),
    .lt          (lt),
    .gt          (gt),
    .branch_cond (branch_cond)
  );

  assign branch_target = next_pc + {{14{instr[15]}}, instr[15:0], 2'b00};

  // Plain case uses 4-state equality, so an X/Z opcode bit matches no item
  // and falls to the no-write default.
  always_comb begin
    dec_ws = 5'd0;
    dec_we = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_ws = instr[15:11];
        dec_we = (funct != FUNCT_JR);
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111,
      OP_LW: begin
        dec_ws = instr[20:16];
        dec_we = 1'b1;
      end
      OP_JAL: begin
        dec_ws = REG_RA;
        dec_we = 1'b1;
      end
      default: begin
        dec_ws = 5'd0;
        dec_we = 1'b0;
      end
    endcase
  end

  // $zero is never a real destination; this also makes BUBBLE a no-write.
  assign ws = dec_ws;
  assign we = dec_we && (dec_ws != 5'd0);

  logic [XLEN-1:0] alu_result_d, alu_result_q;
  logic [XLEN-1:0] b_d,          b_q;
  logic [4:0]      ws_d,         ws_q;
  logic            we_d,         we_q;
  logic [31:0]     next_pc_d,    next_pc_q;

  always_comb begin
    alu_result_d = alu_result;
    b_d          = op_b;
    ws_d         = ws;
    we_d         = we;
    next_pc_d    = next_pc;
    if (flush) begin
      alu_result_d = '0;
      b_d          = '0;
      ws_d         = 5'd0;
      we_d         = 1'b0;
      next_pc_d    = 32'd0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge _d value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_q <= '0;
      b_q          <= '0;
      ws_q         <= 5'd0;
      we_q         <= 1'b0;
      next_pc_q    <= 32'd0;
    end else begin
      alu_result_q <= alu_result_d;
      b_q          <= b_d;
      ws_q         <= ws_d;
      we_q         <= we_d;
      next_pc_q    <= next_pc_d;
    end
  end

  assign exmem_alu_result = alu_result_q;
  assign exmem_b          = b_q;
  assign exmem_ws         = ws_q;
  assign exmem_we         = we_q;
  assign exmem_next_pc    = next_pc_q;

endmodule

// File: tb/tb_ex_stage_unit.sv
// Self-checking bench for ex_stage_unit: directed cases from the test plan
// followed by randomized instructions checked against a behavioural model.
module tb_ex_stage_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, next_pc, op_a, op_b;
  logic [3:0]  aluop;
  logic        alu_src, flush;
  logic [31:0] alu_result, branch_target;
  logic        zero, lt, gt, branch_cond, we;
  logic [4:0]  ws;
  logic [31:0] exmem_alu_result, exmem_b, exmem_next_pc;
  logic [4:0]  exmem_ws;
  logic        exmem_we;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_stage_unit dut (
    .clk              (clk),
    .rst              (rst),
    .instr            (instr),
    .next_pc          (next_pc),
    .op_a             (op_a),
    .op_b             (op_b),
    .aluop            (aluop),
    .alu_src          (alu_src),
    .flush            (flush),
    .alu_result       (alu_result),
    .zero             (zero),
    .lt               (lt),
    .gt               (gt),
    .branch_cond      (branch_cond),
    .branch_target    (branch_target),
    .ws               (ws),
    .we               (we),
    .exmem_alu_result (exmem_alu_result),
    .exmem_b          (exmem_b),
    .exmem_ws         (exmem_ws),
    .exmem_we         (exmem_we),
    .exmem_next_pc    (exmem_next_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic        z, l, g, bc;
    logic [31:0] bt;
    logic [4:0]  ws;
    logic        we;
  } exp_t;

  // Reference model written straight from the instruction-set rules.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input logic src);
    exp_t e;
    logic [31:0] o2, imm_s, imm_z;
    int unsigned sh;
    int unsigned opc;
    imm_z = {16'h0000, i[15:0]};
    imm_s = {{16{i[15]}}, i[15:0]};
    sh    = i[10:6];
    if (!src)                                 o2 = b;
    else if (op == 0 || op == 1 || op == 3)   o2 = imm_z;
    else                                      o2 = imm_s;
    case (op)
      4'd0:  e.res = a & o2;
      4'd1:  e.res = a | o2;
      4'd2:  e.res = a + o2;
      4'd3:  e.res = a ^ o2;
      4'd4:  e.res = ~(a | o2);
      4'd5:  e.res = o2 << sh;
      4'd7:  e.res = ($signed(a) < $signed(o2)) ? 32'd1 : 32'd0;
      4'd8:  e.res = o2 >> sh;
      4'd9:  e.res = $signed(o2) >>> sh;
      4'd10: e.res = (a < o2) ? 32'd1 : 32'd0;
      4'd11: e.res = o2 * 32'd65536;
      default: e.res = a - o2;
    endcase
    e.z = (e.res == 0);
    e.l = $signed(a) < $signed(o2);
    e.g = $signed(a) > $signed(o2);
    case (op)
      4'd12:   e.bc = e.z;
      4'd13:   e.bc = !e.z;
      4'd14:   e.bc = e.l || e.z;
      4'd15:   e.bc = e.g;
      default: e.bc = 1'b0;
    endcase
    e.bt = pc + imm_s * 4;
    opc  = i[31:26];
    if (opc == 0) begin
      e.ws = i[15:11];
      e.we = (i[5:0] != 6'd8);
    end else if ((opc >= 8 && opc <= 15) || opc == 35) begin
      e.ws = i[20:16];
      e.we = 1'b1;
    end else if (opc == 3) begin
      e.ws = 5'd31;
      e.we = 1'b1;
    end else begin
      e.ws = 5'd0;
      e.we = 1'b0;
    end
    if (e.ws == 0) e.we = 1'b0;
    return e;
  endfunction

  task automatic drive(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] op, input logic src,
                       input logic fl);
    instr = i; next_pc = pc; op_a = a; op_b = b; aluop = op; alu_src = src; flush = fl;
  endtask

  // Called at posedge+1; checks combinational outputs, then EX/MEM after the edge.
  task automatic apply(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] op, input logic src,
                       input logic fl);
    exp_t e;
    drive(i, pc, a, b, op, src, fl);
    e = model(i, pc, a, b, op, src);
    #2;
    check("alu_result", alu_result, e.res);
    check("zero", {31'd0, zero}, {31'd0, e.z});
    check("lt", {31'd0, lt}, {31'd0, e.l});
    check("gt", {31'd0, gt}, {31'd0, e.g});
    check("branch_cond", {31'd0, branch_cond}, {31'd0, e.bc});
    check("branch_target", branch_target, e.bt);
    check("ws", {27'd0, ws}, {27'd0, e.ws});
    check("we", {31'd0, we}, {31'd0, e.we});
    @(posedge clk); #1;
    check("exmem_alu_result", exmem_alu_result, fl ? 32'd0 : e.res);
    check("exmem_b", exmem_b, fl ? 32'd0 : b);
    check("exmem_ws", {27'd0, exmem_ws}, fl ? 32'd0 : {27'd0, e.ws});
    check("exmem_we", {31'd0, exmem_we}, fl ? 32'd0 : {31'd0, e.we});
    check("exmem_next_pc", exmem_next_pc, fl ? 32'd0 : pc);
  endtask

  task automatic check_exmem_zero(input string tag);
    check({tag, "_alu"}, exmem_alu_result, 32'd0);
    check({tag, "_b"}, exmem_b, 32'd0);
    check({tag, "_ws"}, {27'd0, exmem_ws}, 32'd0);
    check({tag, "_we"}, {31'd0, exmem_we}, 32'd0);
    check({tag, "_pc"}, exmem_next_pc, 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0]  opc;
    r = $urandom;
    case ($urandom_range(0, 7))
      0, 1: opc = 6'b000000;
      2, 3: opc = 6'(8 + $urandom_range(0, 7));
      4:    opc = 6'b100011;
      5:    opc = 6'b000011;
      default: opc = 6'($urandom_range(0, 63));
    endcase
    r[31:26] = opc;
    if ($urandom_range(0, 7) == 0) r[5:0] = 6'b001000;
    return r;
  endfunction

  localparam logic [31:0] I_ADDI = {6'b001000, 5'd1, 5'd5, 16'h0000};
  localparam logic [31:0] I_ADD  = {6'b000000, 5'd1, 5'd2, 5'd9, 5'd0, 6'b100000};
  localparam logic [31:0] I_JAL  = {6'b000011, 26'h0000010};
  localparam logic [31:0] I_SW   = {6'b101011, 5'd1, 5'd7, 16'h0010};
  localparam logic [31:0] I_LW   = {6'b100011, 5'd1, 5'd7, 16'h0010};

  initial begin
    drive(32'd32, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_exmem_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD, with explicit constants alongside the model
    drive(I_ADD, 32'h40, 32'd5, 32'd7, 4'b0010, 1'b0, 1'b0);
    #1;
    check("add_const", alu_result, 32'd12);
    @(posedge clk); #1;
    check("add_exmem_const", exmem_alu_result, 32'd12);
    apply(I_ADD, 32'h40, 32'd5, 32'd7, 4'b0010, 1'b0, 1'b0);
    // BEQ taken / not taken
    apply(32'h1000_0004, 32'h100, 32'd3, 32'd3, 4'b1100, 1'b0, 1'b0);
    apply(32'h1000_0004, 32'h100, 32'd3, 32'd4, 4'b1100, 1'b0, 1'b0);
    // signed vs unsigned less-than
    drive(I_ADD, 32'h0, 32'hFFFF_FFFF, 32'd1, 4'b0111, 1'b0, 1'b0);
    #1;
    check("slt_const", alu_result, 32'd1);
    check("slt_lt_const", {31'd0, lt}, 32'd1);
    aluop = 4'b1010;
    #1;
    check("sltu_const", alu_result, 32'd0);
    @(posedge clk); #1;
    // branch targets
    drive(32'h0000_FFFF, 32'h100, 32'd0, 32'd0, 4'b0010, 1'b0, 1'b0);
    #1;
    check("bt_neg_const", branch_target, 32'h0000_00FC);
    instr = 32'h0000_0004;
    #1;
    check("bt_pos_const", branch_target, 32'h0000_0110);
    @(posedge clk); #1;
    // destination decode
    apply(I_ADDI, 32'h8, 32'd1, 32'd2, 4'b0010, 1'b1, 1'b0);
    apply(I_ADD, 32'h8, 32'd1, 32'd2, 4'b0010, 1'b0, 1'b0);
    apply(I_JAL, 32'h8, 32'd1, 32'd2, 4'b0010, 1'b0, 1'b0);
    apply(32'd32, 32'h8, 32'd1, 32'd2, 4'b0010, 1'b0, 1'b0);
    apply(I_SW, 32'h8, 32'd1, 32'd2, 4'b0010, 1'b1, 1'b0);
    // immediate extension: logical zero-extends, arithmetic sign-extends
    apply({6'b001101, 5'd1, 5'd3, 16'h8001}, 32'h8, 32'h1234_0000, 32'd0, 4'b0001, 1'b1, 1'b0);
    apply({6'b001000, 5'd1, 5'd3, 16'h8001}, 32'h8, 32'h1234_0000, 32'd0, 4'b0010, 1'b1, 1'b0);

    // asynchronous reset mid-cycle clears EX/MEM without an edge
    apply(I_LW, 32'h200, 32'h10, 32'hABCD, 4'b0010, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_exmem_zero("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    // reload, then flush a lw
    apply(I_LW, 32'h200, 32'h10, 32'hABCD, 4'b0010, 1'b1, 1'b0);
    apply(I_LW, 32'h204, 32'h10, 32'hABCD, 4'b0010, 1'b1, 1'b1);

    for (int n = 0; n < 300; n++) begin
      apply(rand_instr(), $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
